prbs_pattern_checker: RTL and testbench



---
 rtl/prbs_pattern_checker.sv | 174 +++++++++++++++++
 tb/tb_prbs_pattern_checker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module  : prbs_pattern_checker
// Purpose : Hunts for a repeated 32-bit sync word, then checks the PRBS-15
//           byte stream that follows, counting bit errors and tracking lock.
// Revision: 1.0
// ============================================================================
module prbs_pattern_checker #(
    parameter logic [31:0] PATTERN     = 32'hABCDEFCD,
    parameter logic [14:0] SEED        = 15'h7FFF,
    parameter int unsigned LOSS_THRESH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  in,
    input  logic        in_valid,
    input  logic [7:0]  n,
    output logic        pattern_detected,
    output logic        err_byte,
    output logic        sync_loss,
    output logic [15:0] err_count,
    output logic [31:0] byte_count
);

    localparam logic [4:0] THRESH = 5'(LOSS_THRESH);

    typedef enum logic [0:0] {
        HUNT  = 1'b0,
        CHECK = 1'b1
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  idx, idx_nx;
    logic [7:0]  rep, rep_nx;
    logic [7:0]  n_q, n_q_nx;
    logic        n_load, n_load_nx;
    logic [14:0] lfsr, lfsr_nx;
    logic [3:0]  consec, consec_nx;
    logic        det_nx, eb_nx, sl_nx;
    logic [15:0] ec_nx;
    logic [31:0] bc_nx;

    logic [7:0]  n_eff;
    logic [8:0]  n_min;
    logic [7:0]  pat_byte;
    logic [7:0]  exp_byte;
    logic [14:0] lfsr_adv;
    logic [7:0]  diff;
    logic [3:0]  nerr;
    logic [16:0] ec_sum;

    // Eight PRBS-15 steps; the first generated bit lands in the MSB.
    function automatic logic [22:0] prbs8(input logic [14:0] s_in);
        logic [14:0] s;
        logic [7:0]  b;
        logic        bit_n;
        s = s_in;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_n = s[14] ^ s[13];
            b     = {b[6:0], bit_n};
            s     = {s[13:0], bit_n};
        end
        return {b, s};
    endfunction

    always_comb begin
        pat_byte = PATTERN[{~idx, 3'b000} +: 8];
        {exp_byte, lfsr_adv} = prbs8(lfsr);
        diff = in ^ exp_byte;
        nerr = 4'd0;
        for (int i = 0; i < 8; i++) begin
            nerr = nerr + {3'b000, diff[i]};
        end
        ec_sum = {1'b0, err_count} + {13'd0, nerr};
        // The first cycle after reset uses n directly so it counts as captured.
        n_eff = n_load ? n : n_q;
        n_min = (n_eff == 8'd0) ? 9'd1 : {1'b0, n_eff};
    end

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        rep_nx    = rep;
        n_q_nx    = n_load ? n : n_q;
        n_load_nx = 1'b0;
        lfsr_nx   = lfsr;
        consec_nx = consec;
        ec_nx     = err_count;
        bc_nx     = byte_count;
        eb_nx     = 1'b0;
        sl_nx     = 1'b0;

        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (in == pat_byte) begin
                        idx_nx = idx + 2'd1;
                        if (idx == 2'd3) begin
                            if ({1'b0, rep} + 9'd1 == n_min) begin
                                state_nx  = CHECK;
                                rep_nx    = 8'd0;
                                lfsr_nx   = SEED;
                                ec_nx     = 16'd0;
                                bc_nx     = 32'd0;
                                consec_nx = 4'd0;
                            end else begin
                                rep_nx = rep + 8'd1;
                            end
                        end
                    end else begin
                        rep_nx = 8'd0;
                        idx_nx = (in == PATTERN[31:24]) ? 2'd1 : 2'd0;
                    end
                end
                CHECK: begin
                    lfsr_nx = lfsr_adv;
                    ec_nx   = ec_sum[16] ? 16'hFFFF : ec_sum[15:0];
                    bc_nx   = (byte_count == 32'hFFFF_FFFF) ? byte_count
                                                            : byte_count + 32'd1;
                    eb_nx   = (nerr != 4'd0);
                    if (nerr != 4'd0) begin
                        consec_nx = consec + 4'd1;
                        if ({1'b0, consec} + 5'd1 == THRESH) begin
                            state_nx  = HUNT;
                            sl_nx     = 1'b1;
                            idx_nx    = 2'd0;
                            rep_nx    = 8'd0;
                            n_q_nx    = n;
                            consec_nx = 4'd0;
                        end
                    end else begin
                        consec_nx = 4'd0;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end

        det_nx = (state_nx == CHECK);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state            <= HUNT;
            idx              <= 2'd0;
            rep              <= 8'd0;
            n_q              <= 8'd0;
            n_load           <= 1'b1;
            lfsr             <= SEED;
            consec           <= 4'd0;
            pattern_detected <= 1'b0;
            err_byte         <= 1'b0;
            sync_loss        <= 1'b0;
            err_count        <= 16'd0;
            byte_count       <= 32'd0;
        end else begin
            state            <= state_nx;
            idx              <= idx_nx;
            rep              <= rep_nx;
            n_q              <= n_q_nx;
            n_load           <= n_load_nx;
            lfsr             <= lfsr_nx;
            consec           <= consec_nx;
            pattern_detected <= det_nx;
            err_byte         <= eb_nx;
            sync_loss        <= sl_nx;
            err_count        <= ec_nx;
            byte_count       <= bc_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prbs_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_prbs_pattern_checker
// Purpose : Directed and randomized checking of prbs_pattern_checker against
//           a bit-sequence reference model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_prbs_pattern_checker;

    localparam logic [31:0] PAT  = 32'hABCDEFCD;
    localparam int          LOSS = 4;
    localparam int          PER  = 32767;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [7:0]  n = 8'd2;
    logic        pattern_detected, err_byte, sync_loss;
    logic [15:0] err_count;
    logic [31:0] byte_count;

    prbs_pattern_checker #(
        .PATTERN(PAT), .SEED(15'h7FFF), .LOSS_THRESH(LOSS)
    ) dut (
        .CLK(clk), .RST(rst), .in(din), .in_valid(in_valid), .n(n),
        .pattern_detected(pattern_detected), .err_byte(err_byte),
        .sync_loss(sync_loss), .err_count(err_count), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // PRBS-15 as a bit sequence: seed bits, then x[k] = x[k-15] ^ x[k-14].
    bit prbs_x [PER];

    int      m_lock, m_idx, m_rep, m_nq, m_nload, m_bpos, m_consec;
    longint  m_ec, m_bc;
    int      m_eb, m_sl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int j);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) r = {r[6:0], prbs_x[(15 + 8 * j + i) % PER]};
        return r;
    endfunction

    function automatic logic [7:0] pat_at(input int k);
        logic [31:0] p;
        p = PAT;
        return 8'((p >> (8 * (3 - k))) & 32'hFF);
    endfunction

    task automatic model_step(input logic r, input logic v, input logic [7:0] b, input logic [7:0] nn);
        int n_eff, nmin, e;
        if (r) begin
            m_lock = 0; m_idx = 0; m_rep = 0; m_nq = 0; m_nload = 1; m_bpos = 0;
            m_consec = 0; m_ec = 0; m_bc = 0; m_eb = 0; m_sl = 0;
            return;
        end
        n_eff = m_nload ? int'(nn) : m_nq;
        if (m_nload) m_nq = nn;
        m_nload = 0;
        nmin = (n_eff == 0) ? 1 : n_eff;
        m_eb = 0; m_sl = 0;
        if (!v) return;
        if (!m_lock) begin
            if (b == pat_at(m_idx)) begin
                m_idx++;
                if (m_idx == 4) begin
                    m_idx = 0;
                    m_rep++;
                    if (m_rep == nmin) begin
                        m_lock = 1; m_rep = 0; m_bpos = 0;
                        m_ec = 0; m_bc = 0; m_consec = 0;
                    end
                end
            end else begin
                m_rep = 0;
                m_idx = (b == pat_at(0)) ? 1 : 0;
            end
        end else begin
            e = $countones(b ^ exp_byte(m_bpos));
            m_bpos++;
            m_ec = m_ec + e;
            if (m_ec > 65535) m_ec = 65535;
            m_bc++;
            m_eb = (e != 0);
            m_consec = (e != 0) ? m_consec + 1 : 0;
            if (m_consec == LOSS) begin
                m_lock = 0; m_sl = 1; m_idx = 0; m_rep = 0; m_nq = n; m_consec = 0;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] b);
        in_valid = v;
        din      = b;
        @(posedge clk);
        model_step(rst, v, b, n);
        #1;
        check("pattern_detected", {31'd0, pattern_detected}, 32'(m_lock));
        check("err_byte",         {31'd0, err_byte},         32'(m_eb));
        check("sync_loss",        {31'd0, sync_loss},        32'(m_sl));
        check("err_count",        {16'd0, err_count},        32'(m_ec));
        check("byte_count",       byte_count,                32'(m_bc));
    endtask

    task automatic send_pattern(input int reps);
        for (int r = 0; r < reps; r++)
            for (int k = 0; k < 4; k++) drive(1'b1, pat_at(k));
    endtask

    task automatic send_bad(input int cnt);
        for (int i = 0; i < cnt; i++) drive(1'b1, exp_byte(m_bpos) ^ 8'hFF);
    endtask

    initial begin
        for (int k = 0; k < PER; k++) prbs_x[k] = (k < 15) ? 1'b1 : (prbs_x[k-15] ^ prbs_x[k-14]);

        // Reset with a valid pattern byte present
        rst = 1'b1; n = 8'd2;
        drive(1'b1, 8'hAB);
        drive(1'b1, 8'hAB);
        check("reset_det", {31'd0, pattern_detected}, 32'd0);
        check("reset_cnt", {16'd0, err_count} | byte_count, 32'd0);
        rst = 1'b0;

        // Lock with n=2, then clean PRBS
        drive(1'b1, 8'hAB); drive(1'b1, 8'hCD); drive(1'b1, 8'hEF); drive(1'b1, 8'hCD);
        drive(1'b1, 8'hAB); drive(1'b1, 8'hCD); drive(1'b1, 8'hEF);
        check("pre_lock_det", {31'd0, pattern_detected}, 32'd0);
        drive(1'b1, 8'hCD);
        check("lock_det", {31'd0, pattern_detected}, 32'd1);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h02);
        for (int i = 0; i < 100; i++) drive(1'b1, exp_byte(m_bpos));
        check("clean_err", {16'd0, err_count}, 32'd0);
        check("clean_bytes", byte_count, 32'd102);
        check("clean_det", {31'd0, pattern_detected}, 32'd1);

        // Loss of lock after four consecutive errored bytes, then relock
        send_bad(3);
        check("no_loss_yet", {31'd0, pattern_detected}, 32'd1);
        send_bad(1);
        check("loss_pulse", {31'd0, sync_loss}, 32'd1);
        check("loss_det", {31'd0, pattern_detected}, 32'd0);
        check("loss_hold_err", {16'd0, err_count}, 32'd32);
        check("loss_hold_bytes", byte_count, 32'd106);
        drive(1'b0, 8'h00);
        check("loss_single", {31'd0, sync_loss}, 32'd0);
        send_pattern(2);
        check("relock_det", {31'd0, pattern_detected}, 32'd1);
        check("relock_err", {16'd0, err_count}, 32'd0);

        // Bit errors
        drive(1'b1, 8'h01);
        check("bit_err1", {16'd0, err_count}, 32'd1);
        check("bit_eb1", {31'd0, err_byte}, 32'd1);
        drive(1'b1, 8'h02);
        check("bit_eb0", {31'd0, err_byte}, 32'd0);
        drive(1'b1, exp_byte(m_bpos) ^ 8'hFF);
        check("bit_err9", {16'd0, err_count}, 32'd9);
        check("bit_det", {31'd0, pattern_detected}, 32'd1);

        // Hunt restart with n=0
        n = 8'd0;
        send_bad(4);
        drive(1'b1, 8'hAB); drive(1'b1, 8'hCD); drive(1'b1, 8'hAB);
        drive(1'b1, 8'hCD); drive(1'b1, 8'hEF);
        check("restart_pre", {31'd0, pattern_detected}, 32'd0);
        drive(1'b1, 8'hCD);
        check("restart_lock", {31'd0, pattern_detected}, 32'd1);

        // Interrupted repetition resets rep
        n = 8'd2;
        send_bad(4);
        send_pattern(1);
        drive(1'b1, 8'hAB); drive(1'b1, 8'hCD); drive(1'b1, 8'h00);
        send_pattern(1);
        check("interrupt_nolock", {31'd0, pattern_detected}, 32'd0);
        send_pattern(1);
        check("interrupt_lock", {31'd0, pattern_detected}, 32'd1);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            logic       v;
            logic [7:0] b;
            if ($urandom_range(0, 199) == 0) n = 8'($urandom_range(0, 3));
            rst = ($urandom_range(0, 599) == 0);
            v = ($urandom_range(0, 9) != 0);
            if (!m_lock)
                b = ($urandom_range(0, 9) != 0) ? pat_at(m_idx) : 8'($urandom);
            else
                b = exp_byte(m_bpos) ^ (($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00);
            drive(v, b);
        end
        rst = 1'b0;

        // Error counter saturation, then reset while locked
        rst = 1'b1; n = 8'd1;
        drive(1'b0, 8'h00);
        rst = 1'b0;
        send_pattern(1);
        for (int g = 0; g < 2800; g++) begin
            send_bad(3);
            drive(1'b1, exp_byte(m_bpos));
        end
        check("sat_err", {16'd0, err_count}, 32'h0000FFFF);
        check("sat_det", {31'd0, pattern_detected}, 32'd1);
        rst = 1'b1;
        drive(1'b1, exp_byte(m_bpos));
        check("mid_reset_det", {31'd0, pattern_detected}, 32'd0);
        check("mid_reset_cnt", {16'd0, err_count} | byte_count, 32'd0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
